// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction fetch unit: FSM states and special instruction words.
// The FAULT state exists only when FETCH_FAULT_CHECK_EN is defined.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
`ifdef FETCH_FAULT_CHECK_EN
    ,
    S_FAULT  = 2'd3
`endif
  } fetch_state_e;

  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;
  localparam logic [31:0] NOP_WORD    = 32'h0000_0013;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Single-entry instruction fetch stage with redirect, EBREAK drain/halt and optional
// fetch fault checking (enabled by defining FETCH_FAULT_CHECK_EN).
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Redirect,
  input  logic [31:0]  RedirectTarget,
  input  logic         InstrReady,
  input  logic [31:0]  Instruction,
  output logic [31:0]  ReadAddress,
  output logic         InstrValid,
  output logic [31:0]  InstrOut,
  output logic [31:0]  InstrPC,
  output logic         Halted,
`ifdef FETCH_FAULT_CHECK_EN
  output logic         Fault,
`endif
  output fetch_state_e state_dbg
);

  // Handshake: an instruction transfers to decode on a rising edge where InstrValid
  // and InstrReady are both high; InstrReady is ignored while InstrValid is low.

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n;
  logic         valid_n;
  logic [31:0]  out_n, ipc_n;
  logic         can_load;

  assign can_load = !InstrValid || InstrReady;

`ifdef FETCH_FAULT_CHECK_EN
  logic pc_bad;
  assign ReadAddress = pc >> 2;
  assign pc_bad      = (pc[1:0] != 2'b00) || (ReadAddress >= 32'(MEM_WORDS));
  assign Fault       = (state == S_FAULT);
`else
  // Low PC bits are dropped by the shift; the index wraps onto the memory depth.
  assign ReadAddress = (pc >> 2) % 32'(MEM_WORDS);
`endif

  assign Halted    = (state == S_HALTED);
  assign state_dbg = state;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= S_RUN;
      pc         <= RESET_PC;
      InstrValid <= 1'b0;
      InstrOut   <= NOP_WORD;
      InstrPC    <= 32'h0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      InstrValid <= valid_n;
      InstrOut   <= out_n;
      InstrPC    <= ipc_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    valid_n = InstrValid;
    out_n   = InstrOut;
    ipc_n   = InstrPC;
    if (Redirect) begin
      // Redirect discards the current output even if decode is accepting it.
      state_n = S_RUN;
      pc_n    = RedirectTarget;
      valid_n = 1'b0;
    end else begin
      case (state)
        S_RUN: begin
`ifdef FETCH_FAULT_CHECK_EN
          if (can_load && pc_bad) begin
            state_n = S_FAULT;
            valid_n = 1'b0;
          end else
`endif
          if (can_load) begin
            valid_n = 1'b1;
            out_n   = Instruction;
            ipc_n   = pc;
            pc_n    = pc + 32'd4;
            if (Instruction == EBREAK_WORD) state_n = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (InstrReady) begin
            state_n = S_HALTED;
            valid_n = 1'b0;
          end
        end
        S_HALTED: valid_n = 1'b0;
`ifdef FETCH_FAULT_CHECK_EN
        S_FAULT:  valid_n = 1'b0;
`endif
        default:  state_n = S_RUN;
      endcase
    end
  end

endmodule
